// File: rtl/decode_3to8_hs.sv
// decode_3to8_hs: registered 3-to-8 one-hot decoder behind a 2-entry valid/ready FIFO.
//   clk, rst          : clock and synchronous active-high reset
//   in_valid/in_ready : upstream handshake carrying {in_none, in_code}
//   out_valid/out_ready: downstream handshake carrying {out_none, out_onehot}
//   dec_count         : wrapping count of popped beats with none=0
//   Build option DEC_HOLD_EN: keep the last popped beat on out_* while out_valid=0.
module decode_3to8_hs #(
  parameter int IN_W = 3,
  parameter int CNT_W = 16,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_none,
  output logic [CNT_W-1:0] dec_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [IN_W:0] mem_q [2];
  logic [IN_W:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic push, pop;
  logic [IN_W:0] head;
  logic [OUT_W-1:0] head_onehot;
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == EMPTY) ? (push ? ONE : EMPTY) :
              (state_q == ONE)   ? ((push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE) :
                                   (pop ? ONE : FULL);
  end
  always_comb begin
    in_ready  = state_q != FULL;
    out_valid = state_q != EMPTY;
  end
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign head = mem_q[rd_ptr_q];
  assign head_onehot = head[IN_W] ? '0 : OUT_W'(1) << head[IN_W-1:0];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_none, in_code};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d = cnt_q + CNT_W'(pop & ~head[IN_W]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign dec_count = cnt_q;
`ifdef DEC_HOLD_EN
  logic [OUT_W-1:0] last_onehot_q, last_onehot_d;
  logic last_none_q, last_none_d;
  always_comb begin
    last_onehot_d = pop ? head_onehot : last_onehot_q;
    last_none_d = pop ? head[IN_W] : last_none_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_onehot_q <= '0;
      last_none_q <= 1'b0;
    end else begin
      last_onehot_q <= last_onehot_d;
      last_none_q <= last_none_d;
    end
  end
  assign out_onehot = out_valid ? head_onehot : last_onehot_q;
  assign out_none = out_valid ? head[IN_W] : last_none_q;
`else
  assign out_onehot = out_valid ? head_onehot : '0;
  assign out_none = out_valid & head[IN_W];
`endif
endmodule

// File: tb/tb_decode_3to8_hs.sv
// tb_decode_3to8_hs: table-driven scoreboard bench for decode_3to8_hs.
module tb_decode_3to8_hs;
  typedef struct {
    logic [2:0] code;
    logic none;
    logic [7:0] exp_onehot;
    logic exp_none;
  } vec_t;
  typedef struct {
    logic [7:0] onehot;
    logic none;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, in_none = 0;
  logic out_valid, out_ready = 0, out_none;
  logic [2:0] in_code = 0;
  logic [7:0] out_onehot;
  logic [15:0] dec_count;
  logic [15:0] exp_cnt = 0;
  int checks = 0, failures = 0;
  exp_t sb[$];
  vec_t vecs[20];
  int last_wait;
  always #5 clk = ~clk;
  decode_3to8_hs dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_none(in_none), .out_valid(out_valid),
    .out_ready(out_ready), .out_onehot(out_onehot), .out_none(out_none),
    .dec_count(dec_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("pop_without_expected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_onehot", {24'd0, out_onehot}, {24'd0, e.onehot});
        chk("pop_none", {31'd0, out_none}, {31'd0, e.none});
        if (!e.none) exp_cnt = exp_cnt + 16'd1;
      end
    end
  end
  task automatic send(input logic [2:0] c, input logic n, input logic [7:0] eo, input logic en);
    exp_t e;
    int w = 0;
    in_valid = 1; in_code = c; in_none = n;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    last_wait = w;
    if (!in_ready) chk("send_timeout", 0, 1);
    else begin
      e.onehot = eo; e.none = en;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain;
    int w = 0;
    while (sb.size() != 0 && w < 50) begin @(posedge clk); w++; end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask
  initial begin
    int bad;
    int stalls;
    for (int i = 0; i < 20; i++) begin
      vecs[i].code = 3'(i % 8);
      vecs[i].none = 0;
      vecs[i].exp_onehot = 8'b1 << (i % 8);
      vecs[i].exp_none = 0;
    end
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad, stalls;
    cycles(2);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_out_none", out_none, 0);
    chk("rst_dec_count", dec_count, 0);
    @(posedge clk); #1;
    out_ready = 1;
    send(3'b101, 0, 8'b0010_0000, 0);
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_onehot", out_onehot, 8'h20);
    cycles(1);
    chk("t2_dec_count", dec_count, 1);
    out_ready = 0;
    send(3'd7, 0, 8'h80, 0);
    send(3'd0, 0, 8'h01, 0);
    in_valid = 1; in_code = 3'd2; in_none = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_hold_onehot", out_onehot, 8'h80);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(3'd2, 0, 8'h04, 0);
    chk("full_pop_refused_wait", last_wait, 1);
    drain();
    chk("t3_dec_count", dec_count, exp_cnt);
    chk("t3_dec_count_abs", dec_count, 4);
    send(3'b110, 1, 8'h00, 1);
    drain();
    chk("t4_dec_count", dec_count, 4);
    bad = 0; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      send(vecs[i].code, vecs[i].none, vecs[i].exp_onehot, vecs[i].exp_none);
      stalls += last_wait;
      if (out_valid !== 1 || in_ready !== 1) bad++;
    end
    chk("stream_stalls", stalls, 0);
    chk("stream_occupancy_one", bad, 0);
    drain();
    chk("t5_dec_count", dec_count, 24);
    chk("t5_dec_count_model", dec_count, exp_cnt);
    out_ready = 0;
    send(3'd1, 0, 8'h02, 0);
    send(3'd3, 0, 8'h08, 0);
    @(negedge clk);
    chk("pre_rst_full", in_ready, 0);
    @(posedge clk); #1;
    rst = 1;
    sb.delete();
    exp_cnt = 0;
    cycles(1);
    rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_dec_count", dec_count, 0);
    chk("midrst_onehot", out_onehot, 0);
    @(posedge clk); #1;
    out_ready = 1;
    send(3'd6, 0, 8'h40, 0);
    drain();
    cycles(2);
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
`ifdef DEC_HOLD_EN
    chk("idle_hold_onehot", out_onehot, 8'h40);
`else
    chk("idle_zero_onehot", out_onehot, 8'h00);
`endif
    chk("idle_out_none", out_none, 0);
    chk("final_dec_count", dec_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
